// File: rtl/nanov_pkg.sv
// Shared constants and helpers for the nanov MMIO register block.
// Word/address widths, the invalid-address marker, default page and a bit-reverse helper.
package nanov_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t      ADDR_INVALID = 8'hff;
    localparam logic [7:0] DEFAULT_PAGE = 8'h10;

    // Mirror a word end-for-end: bit i takes bit WORD_W-1-i.
    function automatic word_t bit_reverse(input word_t w);
        word_t r;
        r = '0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            r[i] = w[WORD_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/nanov_mmio_regs_if.sv
// CPU-side bus of the nanov MMIO register block.
// master: raw_data_in, latch_addr, latch_data, read_req out; register/readback status in.
// slave : the reverse; regs_out packs reg k at [32k+31:32k].
interface nanov_mmio_regs_if #(
    parameter int unsigned NUM_REGS = 4
);
    import nanov_pkg::*;

    word_t                      raw_data_in;
    logic                       latch_addr;
    logic                       latch_data;
    logic                       read_req;
    logic [NUM_REGS*WORD_W-1:0] regs_out;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       sel_valid;
    logic                       rd_data;
    logic                       rd_busy;

    modport master (
        output raw_data_in, latch_addr, latch_data, read_req,
        input  regs_out, wr_strobe, sel_valid, rd_data, rd_busy
    );

    modport slave (
        input  raw_data_in, latch_addr, latch_data, read_req,
        output regs_out, wr_strobe, sel_valid, rd_data, rd_busy
    );

endinterface

// File: rtl/nanov_shift_out.sv
// Serial readback: captures a word on load, then presents it LSB first, one bit per cycle.
// Ports: cpu_clk, rst (async, active high), load, load_word in; rd_data, rd_busy out.
// rd_busy is high for exactly WORD_W cycles after the load edge; rd_data is 0 when idle.
module nanov_shift_out
    import nanov_pkg::*;
(
    input  logic  cpu_clk,
    input  logic  rst,
    input  logic  load,
    input  word_t load_word,
    output logic  rd_data,
    output logic  rd_busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    word_t            shift_q;
    logic [CNT_W-1:0] cnt_q;

    // Bit 0 is presented straight from the load edge; the shifter holds the remaining bits.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            rd_data <= 1'b0;
            rd_busy <= 1'b0;
        end else if (load && !rd_busy) begin
            shift_q <= load_word >> 1;
            cnt_q   <= '0;
            rd_data <= load_word[0];
            rd_busy <= 1'b1;
        end else if (rd_busy) begin
            if (cnt_q == LAST_BIT) begin
                shift_q <= '0;
                cnt_q   <= '0;
                rd_data <= 1'b0;
                rd_busy <= 1'b0;
            end else begin
                shift_q <= shift_q >> 1;
                cnt_q   <= cnt_q + CNT_W'(1);
                rd_data <= shift_q[0];
            end
        end
    end

endmodule

// File: rtl/nanov_mmio_regs.sv
// MMIO register block: address decode, register file, write strobes and serial readback.
// Ports: cpu_clk, rst (async, active high), bus (nanov_mmio_regs_if.slave):
//   raw_data_in/latch_addr/latch_data/read_req in; regs_out/wr_strobe/sel_valid/rd_data/rd_busy out.
module nanov_mmio_regs
    import nanov_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 4,
    parameter logic [7:0]  PAGE         = DEFAULT_PAGE,
    parameter bit          REVERSE_BITS = 1'b1,
    parameter bit          AUTO_INC     = 1'b0
) (
    input logic              cpu_clk,
    input logic              rst,
    nanov_mmio_regs_if.slave bus
);

    localparam addr_t LAST_ADDR = addr_t'(NUM_REGS - 1);

    word_t               regs_q [NUM_REGS];
    addr_t               addr_q;
    logic                sel_valid_q;
    logic [NUM_REGS-1:0] wr_strobe_q;

    logic                       addr_hit;
    logic                       write_acc;
    logic                       rd_load;
    word_t                      wr_word;
    word_t                      rd_word;
    logic [NUM_REGS*WORD_W-1:0] regs_flat;
    logic                       rd_busy;
    logic                       rd_data;

    assign addr_hit  = (bus.raw_data_in[31:24] == PAGE) && (32'(bus.raw_data_in[7:0]) < NUM_REGS);
    assign write_acc = bus.latch_data && sel_valid_q;
    assign wr_word   = REVERSE_BITS ? bit_reverse(bus.raw_data_in) : bus.raw_data_in;
    assign rd_load   = bus.read_req && sel_valid_q && !rd_busy;

    // Register file and one-cycle write strobes; strobe rises together with the new value.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                regs_q[k] <= '0;
            end
            wr_strobe_q <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                wr_strobe_q[k] <= write_acc && (addr_q == addr_t'(k));
                if (write_acc && (addr_q == addr_t'(k))) begin
                    regs_q[k] <= wr_word;
                end
            end
        end
    end

    // Address register: a new address beats auto-increment; incrementing past the end invalidates.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            addr_q      <= ADDR_INVALID;
            sel_valid_q <= 1'b0;
        end else if (bus.latch_addr) begin
            addr_q      <= addr_hit ? bus.raw_data_in[7:0] : ADDR_INVALID;
            sel_valid_q <= addr_hit;
        end else if (AUTO_INC && write_acc) begin
            if (addr_q == LAST_ADDR) begin
                addr_q      <= ADDR_INVALID;
                sel_valid_q <= 1'b0;
            end else begin
                addr_q <= addr_q + addr_t'(1);
            end
        end
    end

    // Readback source is the pre-edge register value, so a same-cycle write is not seen.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (addr_q == addr_t'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            regs_flat[k*WORD_W +: WORD_W] = regs_q[k];
        end
    end

    nanov_shift_out u_shift_out (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .load      (rd_load),
        .load_word (rd_word),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy)
    );

    assign bus.regs_out  = regs_flat;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.rd_data   = rd_data;
    assign bus.rd_busy   = rd_busy;

endmodule

// File: tb/tb_nanov_mmio_regs.sv
// Bench for nanov_mmio_regs: two instances (AUTO_INC=0 and AUTO_INC=1) share one stimulus
// stream and are compared every cycle against a behavioural model of the register map.
module tb_nanov_mmio_regs;

    logic cpu_clk = 1'b0;
    logic rst     = 1'b1;

    always #5 cpu_clk = ~cpu_clk;

    nanov_mmio_regs_if #(.NUM_REGS(4)) bif0 ();
    nanov_mmio_regs_if #(.NUM_REGS(4)) bif1 ();

    nanov_mmio_regs #(.NUM_REGS(4), .PAGE(8'h10), .REVERSE_BITS(1'b1), .AUTO_INC(1'b0)) dut0 (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .bus     (bif0)
    );

    nanov_mmio_regs #(.NUM_REGS(4), .PAGE(8'h10), .REVERSE_BITS(1'b1), .AUTO_INC(1'b1)) dut1 (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .bus     (bif1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: per instance, register contents, address (-1 = none selected), last strobe,
    // and readback as (captured word, bit index currently shown, -1 = idle).
    logic [31:0] m_regs   [2][4];
    int          m_addr   [2];
    logic [3:0]  m_strobe [2];
    logic [31:0] m_rdword [2];
    int          m_bitpos [2];

    function automatic logic [31:0] rev32(input logic [31:0] w);
        logic [31:0] r;
        r = {<<{w}};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) m_regs[i][k] = '0;
            m_addr[i]   = -1;
            m_strobe[i] = '0;
            m_rdword[i] = '0;
            m_bitpos[i] = -1;
        end
    endtask

    task automatic model_step(input logic la, input logic ld, input logic rr, input logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            automatic int   old = m_addr[i];
            automatic logic acc = ld && (old >= 0);
            // readback advances or starts using the value held before this edge
            if (m_bitpos[i] >= 0) begin
                m_bitpos[i]++;
                if (m_bitpos[i] == 32) m_bitpos[i] = -1;
            end else if (rr && old >= 0) begin
                m_rdword[i] = m_regs[i][old];
                m_bitpos[i] = 0;
            end
            m_strobe[i] = acc ? 4'(1 << old) : 4'b0;
            if (acc) m_regs[i][old] = rev32(d);
            if (la) begin
                m_addr[i] = (d[31:24] == 8'h10 && d[7:0] < 8'd4) ? int'(d[7:0]) : -1;
            end else if (i == 1 && acc) begin
                m_addr[i] = (old + 1 < 4) ? old + 1 : -1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            automatic logic [127:0] exp_regs = {m_regs[i][3], m_regs[i][2], m_regs[i][1], m_regs[i][0]};
            automatic logic         busy     = (m_bitpos[i] >= 0);
            automatic logic         bit_exp  = busy ? m_rdword[i][m_bitpos[i]] : 1'b0;
            chk($sformatf("%s/d%0d/regs", tag, i), (i == 1) ? bif1.regs_out : bif0.regs_out, exp_regs);
            chk($sformatf("%s/d%0d/strobe", tag, i), (i == 1) ? bif1.wr_strobe : bif0.wr_strobe, m_strobe[i]);
            chk($sformatf("%s/d%0d/sel", tag, i), (i == 1) ? bif1.sel_valid : bif0.sel_valid, m_addr[i] >= 0);
            chk($sformatf("%s/d%0d/busy", tag, i), (i == 1) ? bif1.rd_busy : bif0.rd_busy, busy);
            chk($sformatf("%s/d%0d/rd", tag, i), (i == 1) ? bif1.rd_data : bif0.rd_data, bit_exp);
        end
    endtask

    task automatic drive(input logic la, input logic ld, input logic rr, input logic [31:0] d);
        bif0.latch_addr = la;  bif1.latch_addr = la;
        bif0.latch_data = ld;  bif1.latch_data = ld;
        bif0.read_req   = rr;  bif1.read_req   = rr;
        bif0.raw_data_in = d;  bif1.raw_data_in = d;
    endtask

    // One bus cycle: apply inputs, advance the model across the edge, check just after it.
    task automatic step(input string tag, input logic la, input logic ld, input logic rr, input logic [31:0] d);
        drive(la, ld, rr, d);
        model_step(la, ld, rr, d);
        @(posedge cpu_clk);
        #1;
        check_all(tag);
    endtask

    // Reset is asserted between edges and must take effect without a clock.
    task automatic pulse_reset(input string tag);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge cpu_clk);
        #1;
        check_all({tag, "_held"});
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] cap;
        logic [31:0] d;
        logic        la, ld, rr;

        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge cpu_clk);
        pulse_reset("reset");

        // single write, bit-reversed storage, strobe one cycle; first strobe after reset is honoured
        step("r31_addr", 1'b1, 1'b0, 1'b0, 32'h1000_0002);
        step("r31_data", 1'b0, 1'b1, 1'b0, 32'h0000_0001);
        chk("r31_reg2", bif0.regs_out[95:64], 32'h8000_0000);
        chk("r31_strobe", bif0.wr_strobe, 4'b0100);
        step("r31_idle", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("r31_strobe_gone", bif0.wr_strobe, 4'b0000);

        // foreign page: write dropped
        step("r32_addr", 1'b1, 1'b0, 1'b0, 32'h2000_0000);
        step("r32_data", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        chk("r32_sel", bif0.sel_valid, 1'b0);
        // index out of range on the right page
        step("oob_addr", 1'b1, 1'b0, 1'b0, 32'h1000_0004);
        step("oob_data", 1'b0, 1'b1, 1'b0, 32'h1234_5678);

        // auto-increment runs off the end without wrapping
        step("r33_addr", 1'b1, 1'b0, 1'b0, 32'h1000_0002);
        step("r33_a", 1'b0, 1'b1, 1'b0, 32'h0000_0001);
        step("r33_b", 1'b0, 1'b1, 1'b0, 32'h0000_0002);
        chk("r33_sel_after_b", bif1.sel_valid, 1'b0);
        step("r33_c", 1'b0, 1'b1, 1'b0, 32'h0000_0004);
        chk("r33_reg2", bif1.regs_out[95:64], 32'h8000_0000);
        chk("r33_reg3", bif1.regs_out[127:96], 32'h4000_0000);

        // readback of 0xA5 with a mid-read write and a repeated request
        step("r34_addr", 1'b1, 1'b0, 1'b0, 32'h1000_0001);
        step("r34_wr", 1'b0, 1'b1, 1'b0, 32'hA500_0000);
        step("r34_addr2", 1'b1, 1'b0, 1'b0, 32'h1000_0001);
        step("r34_req", 1'b0, 1'b0, 1'b1, 32'h0);
        cap = '0;
        cap[0] = bif0.rd_data;
        for (int c = 1; c <= 32; c++) begin
            step($sformatf("r34_c%0d", c), 1'b0, (c == 5), (c == 10), 32'hFFFF_FFFF);
            if (c < 32) cap[c] = bif0.rd_data;
        end
        chk("r34_seq", cap, 32'h0000_00A5);
        chk("r34_busy_end", bif0.rd_busy, 1'b0);

        // same-cycle read and write shifts out the old value, then reset aborts mid-read
        step("r23_addr", 1'b1, 1'b0, 1'b0, 32'h1000_0001);
        step("r23_rdwr", 1'b0, 1'b1, 1'b1, 32'h0000_0001);
        for (int c = 1; c < 15; c++) step($sformatf("r23_c%0d", c), 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        pulse_reset("r35_rst");
        step("r35_after", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("r35_no_residual", bif0.rd_data, 1'b0);

        // same-cycle address and data: data lands at the old address
        step("r36_addr0", 1'b1, 1'b0, 1'b0, 32'h1000_0000);
        step("r36_both", 1'b1, 1'b1, 1'b0, 32'h1000_0003);
        chk("r36_reg0", bif0.regs_out[31:0], 32'hC000_0008);
        chk("r36_sel", bif1.sel_valid, 1'b1);
        step("r36_next", 1'b0, 1'b1, 1'b0, 32'h0000_0010);
        chk("r36_reg3", bif0.regs_out[127:96], 32'h0800_0000);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            la = ($urandom_range(0, 3) == 0);
            ld = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 7) == 0);
            d  = $urandom;
            if (la && $urandom_range(0, 3) != 0) begin
                d[31:24] = 8'h10;
                d[7:0]   = 8'($urandom_range(0, 5));
            end
            step($sformatf("rand%0d", n), la, ld, rr, d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
